// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared definitions for the PUF response reader: controller state encoding,
// the launch-pair encodings driven onto the delay chain, and the default
// challenge width (which equals the chain select width).
// -----------------------------------------------------------------------------
package puf_pkg;

  // Default challenge / chain select width.
  localparam int DEFAULT_CHAL_W = 32;

  // Launch pair driven onto the chain. Holding 2'b00 discharges the chain;
  // 2'b11 launches both edges of the race.
  localparam logic [1:0] LAUNCH_IDLE = 2'b00;
  localparam logic [1:0] LAUNCH_FIRE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    SETTLE,
    SAMPLE,
    VOTE,
    RESP
  } state_e;

endpackage : puf_pkg

// File: rtl/puf_sync2.sv
// -----------------------------------------------------------------------------
// puf_sync2
// Two-flop synchronizer for a single asynchronous bit (the arbiter cell output).
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, both flops clear to 0
//   d_i   - asynchronous input
//   q_o   - synchronized output, two clk edges behind d_i
// -----------------------------------------------------------------------------
module puf_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse the chain
  // into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : puf_sync2

// File: rtl/puf_response_reader.sv
// -----------------------------------------------------------------------------
// puf_response_reader
// Controller at the far end of the shuffle delay chain. Accepts a challenge,
// drives it onto the chain select bus, runs N_TRIALS races (discharge, launch,
// settle, sample), majority-votes the synchronized arbiter samples and returns
// the result over a valid/ready handshake.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_ready - challenge handshake, req_chal is the challenge
//   sel                 - chain select bus, holds the last accepted challenge
//   launch              - race input pair to the chain
//   arb_in              - arbiter cell output, asynchronous to clk
//   rsp_valid/rsp_ready - response handshake
//   rsp_bit             - majority-vote response bit
//   rsp_ones            - number of trials that sampled 1
//   rsp_stable          - every trial sampled the same value
//   busy                - controller is not idle
// -----------------------------------------------------------------------------
module puf_response_reader
  import puf_pkg::*;
#(
  parameter int CHAL_W     = DEFAULT_CHAL_W,
  parameter int N_TRIALS   = 15,
  parameter int RST_CYC    = 4,
  parameter int SETTLE_CYC = 8,
  parameter int CNT_W      = $clog2(N_TRIALS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CHAL_W-1:0] req_chal,
  output logic [CHAL_W-1:0] sel,
  output logic [1:0]        launch,
  input  logic              arb_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_bit,
  output logic [CNT_W-1:0]  rsp_ones,
  output logic              rsp_stable,
  output logic              busy
);

  // Counter widths are floored at 1 bit so N_TRIALS=1 or 1-cycle phases still
  // elaborate cleanly.
  localparam int CYC_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int TRIAL_W = (N_TRIALS > 1) ? $clog2(N_TRIALS) : 1;

  localparam logic [CYC_W-1:0]   RST_LAST    = CYC_W'(RST_CYC - 1);
  localparam logic [CYC_W-1:0]   SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [TRIAL_W-1:0] TRIAL_LAST  = TRIAL_W'(N_TRIALS - 1);
  localparam logic [CNT_W-1:0]   HALF        = CNT_W'(N_TRIALS / 2);
  localparam logic [CNT_W-1:0]   ALL_ONES    = CNT_W'(N_TRIALS);

  logic arb_sync;

  puf_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (arb_in),
    .q_o   (arb_sync)
  );

  state_e              state_q;
  logic [CHAL_W-1:0]   sel_q;
  logic [1:0]          launch_q;
  logic                req_ready_q;
  logic                busy_q;
  logic                rsp_valid_q;
  logic                rsp_bit_q;
  logic [CNT_W-1:0]    rsp_ones_q;
  logic                rsp_stable_q;
  logic [TRIAL_W-1:0]  trial_cnt_q;
  logic [CNT_W-1:0]    ones_cnt_q;
  logic [CYC_W-1:0]    cycle_cnt_q;

  // Every output is a flop updated on the transition into the state that owns
  // it, so launch and the response fields never glitch toward the chain or
  // the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      launch_q     <= LAUNCH_IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_bit_q    <= 1'b0;
      rsp_ones_q   <= '0;
      rsp_stable_q <= 1'b0;
      trial_cnt_q  <= '0;
      ones_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            sel_q       <= req_chal;
            trial_cnt_q <= '0;
            ones_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end

        LOAD: begin
          if (cycle_cnt_q == RST_LAST) begin
            cycle_cnt_q <= '0;
            launch_q    <= LAUNCH_FIRE;
            state_q     <= FIRE;
          end else begin
            cycle_cnt_q <= cycle_cnt_q + CYC_W'(1);
          end
        end

        FIRE: begin
          state_q <= SETTLE;
        end

        SETTLE: begin
          if (cycle_cnt_q == SETTLE_LAST) begin
            cycle_cnt_q <= '0;
            state_q     <= SAMPLE;
          end else begin
            cycle_cnt_q <= cycle_cnt_q + CYC_W'(1);
          end
        end

        SAMPLE: begin
          // Bounded by N_TRIALS, which CNT_W always holds, so no wrap.
          ones_cnt_q <= ones_cnt_q + CNT_W'(arb_sync);
          if (trial_cnt_q == TRIAL_LAST) begin
            state_q <= VOTE;
          end else begin
            trial_cnt_q <= trial_cnt_q + TRIAL_W'(1);
            launch_q    <= LAUNCH_IDLE;
            state_q     <= LOAD;
          end
        end

        VOTE: begin
          rsp_bit_q    <= (ones_cnt_q > HALF);
          rsp_stable_q <= (ones_cnt_q == '0) || (ones_cnt_q == ALL_ONES);
          rsp_ones_q   <= ones_cnt_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end

        RESP: begin
          // req_ready only returns on the edge that completes the response
          // handshake, so a new request can never overlap it.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            launch_q    <= LAUNCH_IDLE;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign sel        = sel_q;
  assign launch     = launch_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_bit    = rsp_bit_q;
  assign rsp_ones   = rsp_ones_q;
  assign rsp_stable = rsp_stable_q;
  assign busy       = busy_q;

endmodule : puf_response_reader

// File: tb/tb_puf_response_reader.sv
// -----------------------------------------------------------------------------
// tb_puf_response_reader
// Self-checking bench. A timeline model counts clock cycles since each
// accepted request and derives every output from the trial arithmetic
// (RST_CYC + 1 + SETTLE_CYC + 1 cycles per trial, one vote cycle, then the
// response phase). The arbiter input is driven with each trial's bit only
// while the launch pair is high and with the complement during discharge.
// -----------------------------------------------------------------------------
module tb_puf_response_reader;

  localparam int CHAL_W     = 32;
  localparam int N          = 15;
  localparam int RST_CYC    = 4;
  localparam int SETTLE_CYC = 8;
  localparam int CNT_W      = $clog2(N + 1);
  localparam int TRIAL_CYC  = RST_CYC + 1 + SETTLE_CYC + 1;
  localparam int RUN_CYC    = N * TRIAL_CYC;
  // Edges from the accepting edge to the edge that raises rsp_valid:
  // all trials, plus the single vote cycle.
  localparam int LAT        = RUN_CYC + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [CHAL_W-1:0] req_chal;
  logic [CHAL_W-1:0] sel;
  logic [1:0]        launch;
  logic              arb_in;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_bit;
  logic [CNT_W-1:0]  rsp_ones;
  logic              rsp_stable;
  logic              busy;

  always #5 clk = ~clk;

  puf_response_reader #(
    .CHAL_W     (CHAL_W),
    .N_TRIALS   (N),
    .RST_CYC    (RST_CYC),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_chal   (req_chal),
    .sel        (sel),
    .launch     (launch),
    .arb_in     (arb_in),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_bit    (rsp_bit),
    .rsp_ones   (rsp_ones),
    .rsp_stable (rsp_stable),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_ones(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural timeline model
  // ---------------------------------------------------------------------------
  logic [N-1:0]      trial_bits;  // bit i = arbiter value for trial i
  bit                m_busy;
  int                m_k;         // cycle index since the accepting edge (1 = first)
  logic [CHAL_W-1:0] m_sel;
  logic [N-1:0]      m_bits;
  int                m_ones;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_sel  <= '0;
      m_bits <= '0;
      m_ones <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy <= 1'b1;
        m_k    <= 1;
        m_sel  <= req_chal;
        m_bits <= trial_bits;
        m_ones <= count_ones(trial_bits);
      end
    end else if (m_k > LAT && rsp_ready) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  // Arbiter driver: trial bit while launch is high, complement while the chain
  // discharges, so a sample taken during discharge would corrupt the count.
  always @(negedge clk) begin
    if (m_busy && m_k >= 1 && m_k <= RUN_CYC) begin
      if ((m_k - 1) % TRIAL_CYC >= RST_CYC) arb_in = m_bits[(m_k - 1) / TRIAL_CYC];
      else                                  arb_in = ~m_bits[(m_k - 1) / TRIAL_CYC];
    end else begin
      arb_in = 1'($urandom);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", 64'(req_ready), 64'(!m_busy));
      check("busy", 64'(busy), 64'(m_busy));
      check("sel", 64'(sel), 64'(m_sel));
      check("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_k > LAT));
      if (m_busy && m_k <= RUN_CYC)
        check("launch_trial", 64'(launch), ((m_k - 1) % TRIAL_CYC < RST_CYC) ? 64'h0 : 64'h3);
      else if (m_busy)
        check("launch_hold", 64'(launch), 64'h3);
      if (m_busy && m_k > LAT) begin
        check("rsp_ones", 64'(rsp_ones), 64'(m_ones));
        check("rsp_bit", 64'(rsp_bit), 64'(2 * m_ones > N));
        check("rsp_stable", 64'(rsp_stable), 64'(m_ones == 0 || m_ones == N));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic do_request(input logic [CHAL_W-1:0] chal);
    @(negedge clk);
    req_valid = 1'b1;
    req_chal  = chal;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("sel_after_accept", 64'(sel), 64'(chal));
  endtask

  // Called right after do_request (one negedge into the run). Returns the
  // number of edges from the accepting edge to the edge that raised rsp_valid.
  task automatic wait_rsp(output int lat);
    int n = 1;
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) check("rsp_timeout", 64'(0), 64'(1));
    lat = n - 1;
  endtask

  task automatic respond();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("req_ready_after_hs", 64'(req_ready), 64'(1));
  endtask

  task automatic directed(input logic [CHAL_W-1:0] chal, input logic [N-1:0] bits,
                          input int e_ones, input bit e_bit, input bit e_stable);
    int lat;
    trial_bits = bits;
    do_request(chal);
    wait_rsp(lat);
    check("latency", 64'(lat), 64'(LAT));
    check("lit_ones", 64'(rsp_ones), 64'(e_ones));
    check("lit_bit", 64'(rsp_bit), 64'(e_bit));
    check("lit_stable", 64'(rsp_stable), 64'(e_stable));
    respond();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [CNT_W-1:0]  hold_ones;
    logic              hold_bit;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_chal   = '0;
    rsp_ready  = 1'b0;
    trial_bits = '0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_launch", 64'(launch), 64'(0));
    check("rst_sel", 64'(sel), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_ones", 64'(rsp_ones), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    #2 rst_n = 1'b1;

    // Hand-computed response patterns.
    directed(32'hDEADBEEF, 15'h7FFF, 15, 1'b1, 1'b1);
    directed(32'h1234_5678, 15'h00FF, 8, 1'b1, 1'b0);
    directed(32'hCAFE_F00D, 15'h007F, 7, 1'b0, 1'b0);
    directed(32'h0F0F_0F0F, 15'h0000, 0, 1'b0, 1'b1);

    // Stall: consumer holds rsp_ready low for 50 cycles; a request pulsed
    // meanwhile must be ignored.
    trial_bits = N'($urandom);
    do_request(32'h5555_AAAA);
    wait_rsp(lat);
    hold_ones = rsp_ones;
    hold_bit  = rsp_bit;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 20) begin
        req_valid = 1'b1;
        req_chal  = 32'hFFFF_0000;
      end else begin
        req_valid = 1'b0;
      end
    end
    check("stall_ones_held", 64'(rsp_ones), 64'(hold_ones));
    check("stall_bit_held", 64'(rsp_bit), 64'(hold_bit));
    check("stall_sel_kept", 64'(sel), 64'(32'h5555_AAAA));
    check("stall_req_ready", 64'(req_ready), 64'(0));
    respond();

    // Reset during SETTLE of trial 5 (cycle index 5*TRIAL_CYC + 9).
    trial_bits = N'($urandom);
    do_request(32'hA5A5_0F0F);
    n = 0;
    while (m_k != 5 * TRIAL_CYC + 9 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reached_settle5", 64'(m_k), 64'(5 * TRIAL_CYC + 9));
    #2 rst_n = 1'b0;
    #1;
    check("abort_launch", 64'(launch), 64'(0));
    check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    check("abort_req_ready", 64'(req_ready), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    trial_bits = N'($urandom);
    do_request(32'h0000_0001);
    wait_rsp(lat);
    check("post_reset_latency", 64'(lat), 64'(LAT));
    respond();

    // Randomized requests with random response back-pressure.
    for (int r = 0; r < 8; r++) begin
      trial_bits = N'($urandom);
      do_request($urandom);
      wait_rsp(lat);
      check("rand_latency", 64'(lat), 64'(LAT));
      repeat ($urandom_range(0, 6)) @(negedge clk);
      respond();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_puf_response_reader
